// File: rtl/banked_fifo.sv
// Synchronous FIFO built from LANES independent LANE_W-wide banks sharing one pointer pair.
// Registered read data, occupancy count, registered status flags and sticky over/underflow.
module banked_fifo #(
  parameter int unsigned LANE_W       = 16,
  parameter int unsigned LANES        = 4,
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned AFULL_THRESH = DEPTH - 2,
  localparam int unsigned AW          = $clog2(DEPTH),
  localparam int unsigned DW          = LANES * LANE_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic [DW-1:0] din,
  input  logic          wr_en,
  input  logic          rd_en,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          underflow
);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          dout_valid_q, dout_valid_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          almost_full_q, almost_full_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;

  logic          wr_acc_c;
  logic          rd_acc_c;
  logic [DW-1:0] rd_word_c;

  // Flush swallows any request in its cycle; full/empty gate acceptance.
  assign wr_acc_c = wr_en & ~full_q & ~flush & ~rst;
  assign rd_acc_c = rd_en & ~empty_q & ~flush & ~rst;

  // One simple dual-port RAM per lane; contents are never reset.
  for (genvar i = 0; i < int'(LANES); i++) begin : g_bank
    logic [LANE_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
      if (wr_acc_c) begin
        mem[wr_ptr_q] <= din[i*LANE_W +: LANE_W];
      end
    end

    assign rd_word_c[i*LANE_W +: LANE_W] = mem[rd_ptr_q];
  end

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    dout_d        = dout_q;
    dout_valid_d  = 1'b0;
    overflow_d    = overflow_q;
    underflow_d   = underflow_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_acc_c) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (rd_acc_c) begin
        rd_ptr_d     = rd_ptr_q + AW'(1);
        dout_d       = rd_word_c;
        dout_valid_d = 1'b1;
      end
      case ({wr_acc_c, rd_acc_c})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
      if (wr_en && full_q) begin
        overflow_d = 1'b1;
      end
      if (rd_en && empty_q) begin
        underflow_d = 1'b1;
      end
    end

    // Flags decoded from next count so they line up with the registered count.
    full_d        = (count_d == (AW+1)'(DEPTH));
    empty_d       = (count_d == '0);
    almost_full_d = (count_d >= (AW+1)'(AFULL_THRESH));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      dout_q        <= '0;
      dout_valid_q  <= 1'b0;
      full_q        <= 1'b0;
      empty_q       <= 1'b1;
      almost_full_q <= 1'b0;
      overflow_q    <= 1'b0;
      underflow_q   <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      dout_q        <= dout_d;
      dout_valid_q  <= dout_valid_d;
      full_q        <= full_d;
      empty_q       <= empty_d;
      almost_full_q <= almost_full_d;
      overflow_q    <= overflow_d;
      underflow_q   <= underflow_d;
    end
  end

  assign dout        = dout_q;
  assign dout_valid  = dout_valid_q;
  assign full        = full_q;
  assign empty       = empty_q;
  assign almost_full = almost_full_q;
  assign count       = count_q;
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;

endmodule
